stdout_ctrl: RTL and testbench

//  Simulation-console controller between the core MMIO store path and a character sink.

---
 rtl/stdout_ctrl.sv | 140 ++++++++++++++
 tb/tb_stdout_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdout_ctrl.sv
// Console store path: claims MMIO stores in an 8-byte window, unpacks them into a byte FIFO
// and drains one byte per char_valid/char_ready handshake. Define STDOUT_CTRL_NUL_STRIP_EN to drop 0x00 bytes.
package stdout_ctrl_pkg;
    typedef enum logic [1:0] {
        NO_STORE    = 2'd0,
        STORE_BYTE  = 2'd1,
        STORE_WORD  = 2'd2,
        STORE_DWORD = 2'd3
    } mem_store_type_t;
endpackage

module stdout_ctrl
    import stdout_ctrl_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_enable,
    input  logic [63:0]                     i_addr,
    input  mem_store_type_t                 i_mem_store_type,
    input  logic [63:0]                     i_w_data,
    output logic                            o_stall,
    output logic                            o_stdout_taken,
    output logic                            o_char_valid,
    output logic [7:0]                      o_char_data,
    input  logic                            i_char_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {S_IDLE, S_UNPACK} state_t;

    state_t          r_state;
    logic [63:0]     r_staging;
    logic [3:0]      r_n;
    logic            r_taken;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_hit;
    logic            w_accept;
    logic            w_full;
    logic            w_keep;
    logic            w_emit;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_byte;
    logic [3:0]      w_n;

    assign w_hit    = i_enable && (i_addr >= BASE_ADDR) && (i_addr < BASE_ADDR + 64'd8)
                      && (i_mem_store_type != NO_STORE);
    assign w_accept = w_hit && (r_state == S_IDLE);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_byte   = r_staging[7:0];

`ifdef STDOUT_CTRL_NUL_STRIP_EN
    // A NUL byte never occupies a slot, so it may retire even while the FIFO is full.
    assign w_keep = (w_byte != 8'h00);
    assign w_emit = (r_state == S_UNPACK) && (!w_keep || !w_full);
`else
    assign w_keep = 1'b1;
    assign w_emit = (r_state == S_UNPACK) && !w_full;
`endif

    assign w_push = w_emit && w_keep;
    assign w_pop  = (r_count != '0) && i_char_ready;

    always_comb begin
        w_n = 4'd0;
        case (i_mem_store_type)
            STORE_BYTE:  w_n = 4'd1;
            STORE_WORD:  w_n = 4'd4;
            STORE_DWORD: w_n = 4'd8;
            default:     w_n = 4'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_staging <= '0;
            r_n       <= '0;
            r_taken   <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_taken <= w_accept;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_staging <= i_w_data;
                        r_n       <= w_n;
                        r_state   <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (w_emit) begin
                        r_staging <= {8'h00, r_staging[63:8]};
                        r_n       <= r_n - 4'd1;
                        if (r_n == 4'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    assign o_stall        = w_hit && (r_state != S_IDLE);
    assign o_stdout_taken = r_taken;
    assign o_char_valid   = (r_count != '0);
    // Storage is not reset, so the head is masked to keep char_data at 0 while empty.
    assign o_char_data    = o_char_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign o_fifo_count   = r_count;

endmodule

// File: tb/tb_stdout_ctrl.sv
// Bench for stdout_ctrl: directed steps plus a randomized phase, all checked against a
// byte-stream scoreboard. Honors STDOUT_CTRL_NUL_STRIP_EN in its reference model.
module tb_stdout_ctrl;
    import stdout_ctrl_pkg::*;

    localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
    localparam int          DEPTH = 16;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [63:0]     addr;
    mem_store_type_t st;
    logic [63:0]     wdata;
    logic            stall;
    logic            taken;
    logic            cvalid;
    logic [7:0]      cdata;
    logic            ready;
    logic [4:0]      fcount;

    stdout_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_addr(addr),
        .i_mem_store_type(st), .i_w_data(wdata), .o_stall(stall),
        .o_stdout_taken(taken), .o_char_valid(cvalid), .o_char_data(cdata),
        .i_char_ready(ready), .o_fifo_count(fcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         taken_seen = 0;
    int         taken_exp  = 0;
    int         rx_count   = 0;
    bit         rdone      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input bit en, input logic [63:0] a, input mem_store_type_t t);
        return en && (a >= BASE) && (a <= BASE + 64'd7) && (t != NO_STORE);
    endfunction

    function automatic int model_n(input mem_store_type_t t);
        return (t == STORE_BYTE) ? 1 : (t == STORE_WORD) ? 4 : (t == STORE_DWORD) ? 8 : 0;
    endfunction

    // Expected console stream: bytes of the store in little-endian memory order.
    task automatic model_push(input mem_store_type_t t, input logic [63:0] d);
        logic [7:0] b;
        for (int i = 0; i < model_n(t); i++) begin
            b = d[8*i +: 8];
`ifdef STDOUT_CTRL_NUL_STRIP_EN
            if (b != 8'h00) exp_q.push_back(b);
`else
            exp_q.push_back(b);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a store, waits out any stall, and returns just after the accepting edge.
    task automatic do_store(input mem_store_type_t t, input logic [63:0] a, input logic [63:0] d,
                            input bit en, output int stalled);
        bit h;
        h = model_hit(en, a, t);
        enable = en; addr = a; st = t; wdata = d;
        #1;
        stalled = 0;
        while (stall && stalled < 200) begin
            @(posedge clk);
            #2;
            stalled++;
        end
        check("stall_bound", 64'(stalled < 200), 1);
        @(posedge clk);
        #1;
        enable = 1'b0; st = NO_STORE; addr = '0; wdata = '0;
        check("taken_pulse", 64'(taken), 64'(h));
        if (h) begin
            model_push(t, d);
            taken_exp++;
        end
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        ready = 1'b1;
        while ((exp_q.size() != 0 || fcount != 0) && c < 500) begin
            tick();
            c++;
        end
        repeat (12) tick();
        check({tag, "_drain_bound"}, 64'(c < 500), 1);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 0);
        check({tag, "_fifo_empty"}, 64'(fcount), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && taken) taken_seen++;
        if (rst_n && cvalid && ready) begin
            rx_count++;
            check("char_pending", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("char_data", 64'(cdata), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, rx0, nexp;
        logic [63:0] d;
        mem_store_type_t t;
        logic [63:0] a;
        bit en;

        rst_n = 1'b0; enable = 1'b0; addr = '0; st = NO_STORE; wdata = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(cvalid), 0);
        check("rst_count", 64'(fcount), 0);
        check("rst_stall", 64'(stall), 0);
        check("rst_taken", 64'(taken), 0);
        check("rst_data", 64'(cdata), 0);
        rst_n = 1'b1;
        tick();

        // Hello string in one DWORD
        ready = 1'b1;
        rx0 = rx_count;
        do_store(STORE_DWORD, BASE, 64'h000A_216F_6C6C_6548, 1'b1, s);
        wait_drain("t1");
`ifdef STDOUT_CTRL_NUL_STRIP_EN
        nexp = 7;
`else
        nexp = 8;
`endif
        check("t1_nchars", 64'(rx_count - rx0), 64'(nexp));

        // Single byte at an unaligned address; latency check
        ready = 1'b0;
        do_store(STORE_BYTE, BASE + 64'd3, 64'hDEAD_BEEF_1234_5641, 1'b1, s);
        check("t2_valid_at_T", 64'(cvalid), 0);
        tick();
        check("t2_valid_at_T1", 64'(cvalid), 1);
        check("t2_data", 64'(cdata), 64'h41);
        check("t2_count", 64'(fcount), 1);
        tick();
        check("t2_count_hold", 64'(fcount), 1);
        wait_drain("t2");

        // Three back-to-back DWORDs against a stuck sink
        ready = 1'b0;
        do_store(STORE_DWORD, BASE, 64'h0807_0605_0403_0201, 1'b1, s);
        do_store(STORE_DWORD, BASE, 64'h1817_1615_1413_1211, 1'b1, s2);
        check("t3_second_stalled", 64'(s2 > 0), 1);
        do_store(STORE_DWORD, BASE + 64'd4, 64'h2827_2625_2423_2221, 1'b1, s);
        repeat (10) tick();
        check("t3_count_sat", 64'(fcount), 16);
        enable = 1'b1; addr = BASE; st = STORE_BYTE; wdata = 64'h33;
        #1;
        check("t3_fourth_stall", 64'(stall), 1);
        enable = 1'b0; st = NO_STORE;
        tick();
        rx0 = rx_count;
        wait_drain("t3");
        check("t3_nchars", 64'(rx_count - rx0), 24);

        // Stores that must be ignored
        ready = 1'b1;
        rx0 = rx_count;
        do_store(STORE_DWORD, BASE + 64'd8, 64'h4141_4141_4141_4141, 1'b1, s);
        do_store(STORE_BYTE, BASE - 64'd1, 64'h42, 1'b1, s);
        do_store(NO_STORE, BASE, 64'h43, 1'b1, s);
        do_store(STORE_WORD, BASE, 64'h4444_4444, 1'b0, s);
        repeat (3) tick();
        check("t4_count", 64'(fcount), 0);
        check("t4_nchars", 64'(rx_count - rx0), 0);

        // Reset during unpack with 3 bytes queued
        ready = 1'b0;
        do_store(STORE_DWORD, BASE, 64'h5857_5655_5453_5251, 1'b1, s);
        repeat (3) tick();
        check("t5_count_pre", 64'(fcount), 3);
        enable = 1'b1; addr = BASE; st = STORE_BYTE; wdata = 64'h59;
        #1;
        check("t5_stall_pre", 64'(stall), 1);
        rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(cvalid), 0);
        check("t5_count", 64'(fcount), 0);
        check("t5_stall", 64'(stall), 0);
        exp_q.delete();
        enable = 1'b0; st = NO_STORE; wdata = '0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t5_valid_after", 64'(cvalid), 0);
        check("t5_count_after", 64'(fcount), 0);
        rx0 = rx_count;
        ready = 1'b1;
        repeat (5) tick();
        check("t5_no_stale", 64'(rx_count - rx0), 0);

        // Simultaneous push and pop at count 1
        ready = 1'b0;
        do_store(STORE_BYTE, BASE, 64'h58, 1'b1, s);
        tick();
        check("t6_count1", 64'(fcount), 1);
        do_store(STORE_BYTE, BASE + 64'd1, 64'h59, 1'b1, s);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t6_count_same", 64'(fcount), 1);
        check("t6_new_head", 64'(cdata), 64'h59);
        tick();
        check("t6_count_hold", 64'(fcount), 1);
        wait_drain("t6");

        // Randomized stores with a randomly stalling sink
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    t  = mem_store_type_t'($urandom_range(0, 3));
                    a  = BASE - 64'd2 + 64'($urandom_range(0, 11));
                    en = ($urandom_range(0, 7) != 0);
                    d  = {$urandom, $urandom};
                    for (int j = 0; j < 8; j++) begin
                        if ($urandom_range(0, 3) == 0) d[8*j +: 8] = 8'h00;
                    end
                    do_store(t, a, d, en, s);
                    repeat ($urandom_range(0, 3)) tick();
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        wait_drain("rand");
        check("taken_total", 64'(taken_seen), 64'(taken_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
